// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder. It packs one operation request per handshake
// into a 32-bit instruction word and emits it through a one-deep registered output stage.
module instr_encoder #(
  parameter int          CNT_W     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_class,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7b5,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic             out_err,
  output logic [CNT_W-1:0] word_count,
  output logic [7:0]       err_count
);

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam logic [3:0] CLS_R     = 4'd0;
  localparam logic [3:0] CLS_I     = 4'd1;
  localparam logic [3:0] CLS_LW    = 4'd2;
  localparam logic [3:0] CLS_SW    = 4'd3;
  localparam logic [3:0] CLS_BEQ   = 4'd4;
  localparam logic [3:0] CLS_JAL   = 4'd5;
  localparam logic [3:0] CLS_JALR  = 4'd6;
  localparam logic [3:0] CLS_LUI   = 4'd7;
  localparam logic [3:0] CLS_AUIPC = 4'd8;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic signed [31:0] imm_s;
  logic               fits_i12;
  logic               fits_b13;
  logic               fits_j21;
  logic               fits_shamt;
  logic               is_shift;
  logic [31:0]        enc_word;
  logic               enc_err;
  logic [31:0]        enc_instr;

  assign imm_s      = in_imm;
  assign fits_i12   = (imm_s >= -32'sd2048)    && (imm_s <= 32'sd2047);
  assign fits_b13   = (imm_s >= -32'sd4096)    && (imm_s <= 32'sd4094)    && !in_imm[0];
  assign fits_j21   = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !in_imm[0];
  assign fits_shamt = (imm_s >= 32'sd0)        && (imm_s <= 32'sd31);
  assign is_shift   = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

  // Field packing per class; unused register fields are tied to zero.
  always_comb begin
    enc_word = NOP_WORD;
    enc_err  = 1'b0;
    case (in_class)
      CLS_R: begin
        enc_word = {1'b0, in_funct7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
      end
      CLS_I: begin
        if (is_shift) begin
          // SLLI only has a zero bit 30; SRAI/SRLI take it from funct7b5.
          enc_err  = !fits_shamt || ((in_funct3 == 3'b001) && in_funct7b5);
          enc_word = {1'b0, in_funct7b5 & in_funct3[2], 5'b0, in_imm[4:0],
                      in_rs1, in_funct3, in_rd, OP_I};
        end else begin
          enc_err  = !fits_i12;
          enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
        end
      end
      CLS_LW: begin
        enc_err  = !fits_i12;
        enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LW};
      end
      CLS_SW: begin
        enc_err  = !fits_i12;
        enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OP_SW};
      end
      CLS_BEQ: begin
        enc_err  = !fits_b13;
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                    in_imm[4:1], in_imm[11], OP_BEQ};
      end
      CLS_JAL: begin
        enc_err  = !fits_j21;
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
      end
      CLS_JALR: begin
        enc_err  = !fits_i12;
        enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
      end
      CLS_LUI: begin
        enc_err  = (in_imm[11:0] != 12'd0);
        enc_word = {in_imm[31:12], in_rd, OP_LUI};
      end
      CLS_AUIPC: begin
        enc_err  = (in_imm[11:0] != 12'd0);
        enc_word = {in_imm[31:12], in_rd, OP_AUIPC};
      end
      default: begin
        enc_err  = 1'b1;
      end
    endcase
  end

  assign enc_instr = enc_err ? NOP_WORD : enc_word;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_instr_q, out_instr_d;
  logic [31:0]      out_pc_q,    out_pc_d;
  logic             out_err_q,   out_err_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;
  logic [7:0]       err_count_q,  err_count_d;
  logic             accept;

  assign in_ready = !clear && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    out_err_d    = out_err_q;
    word_count_d = word_count_q;
    err_count_d  = err_count_q;
    if (clear) begin
      out_valid_d  = 1'b0;
      word_count_d = '0;
      err_count_d  = '0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      if (accept) begin
        out_valid_d  = 1'b1;
        out_instr_d  = enc_instr;
        out_err_d    = enc_err;
        out_pc_d     = BASE_ADDR + (32'(word_count_q) << 2);
        word_count_d = word_count_q + CNT_W'(1);
        if (enc_err && (err_count_q != 8'hFF)) begin
          err_count_d = err_count_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= NOP_WORD;
      out_pc_q     <= BASE_ADDR;
      out_err_q    <= 1'b0;
      word_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      out_err_q    <= out_err_d;
      word_count_q <= word_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_instr  = out_instr_q;
  assign out_pc     = out_pc_q;
  assign out_err    = out_err_q;
  assign word_count = word_count_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words are queued at accept time and
// compared when the output stage hands them off.
module tb_instr_encoder;

  localparam int          CNT_W = 16;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_class = '0;
  logic [4:0]       in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]       in_funct3 = '0;
  logic             in_funct7b5 = 1'b0;
  logic [31:0]      in_imm = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_instr;
  logic [31:0]      out_pc;
  logic             out_err;
  logic [CNT_W-1:0] word_count;
  logic [7:0]       err_count;

  instr_encoder #(.CNT_W(CNT_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_err(out_err),
    .word_count(word_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
    logic [31:0] wc;
    logic [31:0] ec;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   m_wc  = 0;
  int   m_ec  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Output monitor: sampled on the falling edge, a handoff happens at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !clear) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_word", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("instr", out_instr, e.instr);
        check_eq("pc", out_pc, e.pc);
        check_eq("err", {31'd0, out_err}, {31'd0, e.err});
        check_eq("word_count", {16'd0, word_count}, e.wc);
        check_eq("err_count", {24'd0, err_count}, e.ec);
        $display("word pc=0x%08h instr=0x%08h err=%0d", out_pc, out_instr, out_err);
      end
    end
  end

  task automatic send(input logic [3:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                      input logic [31:0] imm, input logic [31:0] exp_instr,
                      input logic exp_err, output int waits);
    exp_t e;
    @(posedge clk); #1;
    in_valid = 1'b1; in_class = cls; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7b5 = f7; in_imm = imm;
    waits = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 50) begin
        check_eq("accept_timeout", 32'd0, 32'd1);
        return;
      end
    end
    e.instr = exp_instr;
    e.pc    = BASE + 32'(m_wc) * 32'd4;
    e.err   = exp_err;
    m_wc    = (m_wc + 1) % (1 << CNT_W);
    if (exp_err && m_ec < 255) m_ec++;
    e.wc = 32'(m_wc);
    e.ec = 32'(m_ec);
    sb_q.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_left", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    clear = 1'b1;
    in_valid = 1'b1; in_class = 4'd0;
    @(negedge clk);
    check_eq("ready_in_clear", {31'd0, in_ready}, 32'd0);
    check_eq("wc_before_clear", {16'd0, word_count}, 32'(m_wc));
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
    m_wc = 0;
    m_ec = 0;
    @(negedge clk);
    check_eq("clr_valid", {31'd0, out_valid}, 32'd0);
    check_eq("clr_wc", {16'd0, word_count}, 32'd0);
    check_eq("clr_ec", {24'd0, err_count}, 32'd0);
  endtask

  initial begin
    int   w;
    exp_t ea;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_instr", out_instr, NOP);
    check_eq("rst_pc", out_pc, BASE);
    check_eq("rst_err", {31'd0, out_err}, 32'd0);
    check_eq("rst_wc", {16'd0, word_count}, 32'd0);
    check_eq("rst_ec", {24'd0, err_count}, 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Encoding table, issued back to back.
    send(4'd0, 5'd3,  5'd1, 5'd2, 3'd0, 1'b0, 32'd0,        32'h002081B3, 1'b0, w);
    send(4'd0, 5'd3,  5'd1, 5'd2, 3'd0, 1'b1, 32'd0,        32'h402081B3, 1'b0, w);
    send(4'd1, 5'd5,  5'd0, 5'd7, 3'd0, 1'b0, 32'hFFFFFFFF, 32'hFFF00293, 1'b0, w);
    send(4'd3, 5'd9,  5'd1, 5'd2, 3'd0, 1'b0, 32'd8,        32'h0020A423, 1'b0, w);
    send(4'd7, 5'd10, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000, 32'h12345537, 1'b0, w);
    send(4'd4, 5'd0,  5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0, w);
    send(4'd5, 5'd1,  5'd0, 5'd0, 3'd0, 1'b0, 32'd2048,     32'h001000EF, 1'b0, w);
    send(4'd4, 5'd0,  5'd1, 5'd2, 3'd0, 1'b0, 32'd3,        NOP,          1'b1, w);
    send(4'd1, 5'd5,  5'd6, 5'd0, 3'd5, 1'b1, 32'd3,        32'h40335293, 1'b0, w);
    send(4'd1, 5'd5,  5'd6, 5'd0, 3'd1, 1'b1, 32'd3,        NOP,          1'b1, w);
    send(4'd1, 5'd1,  5'd0, 5'd0, 3'd0, 1'b0, 32'd2047,     32'h7FF00093, 1'b0, w);
    send(4'd1, 5'd1,  5'd0, 5'd0, 3'd0, 1'b0, 32'd2048,     NOP,          1'b1, w);
    send(4'd2, 5'd4,  5'd2, 5'd0, 3'd0, 1'b0, 32'hFFFFF800, 32'h80012203, 1'b0, w);
    send(4'd6, 5'd0,  5'd1, 5'd0, 3'd0, 1'b0, 32'd0,        32'h00008067, 1'b0, w);
    send(4'd8, 5'd3,  5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFFF000, 32'hFFFFF197, 1'b0, w);
    send(4'd7, 5'd3,  5'd0, 5'd0, 3'd0, 1'b0, 32'h12345001, NOP,          1'b1, w);
    send(4'd4, 5'd0,  5'd1, 5'd2, 3'd0, 1'b0, 32'd4096,     NOP,          1'b1, w);
    send(4'd5, 5'd0,  5'd0, 5'd0, 3'd0, 1'b0, 32'hFFF00000, 32'h8000006F, 1'b0, w);
    send(4'd9, 5'd1,  5'd1, 5'd1, 3'd0, 1'b0, 32'd0,        NOP,          1'b1, w);
    idle();
    drain();

    // Clear while a word is pending with word_count at 5.
    do_clear();
    for (int i = 0; i < 5; i++) begin
      send(4'd0, 5'(i + 1), 5'd1, 5'd2, 3'd0, 1'b0, 32'd0,
           32'h00208033 | (32'(i + 1) << 7), 1'b0, w);
    end
    do_clear();
    send(4'd6, 5'd0, 5'd1, 5'd0, 3'd0, 1'b0, 32'd0, 32'h00008067, 1'b0, w);
    idle();
    drain();

    // Backpressure: hold out_ready low for three cycles with requests waiting.
    out_ready = 1'b0;
    send(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 32'h002081B3, 1'b0, w);
    ea = sb_q[sb_q.size() - 1];
    fork
      begin
        int wb, wc2;
        send(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0, 32'h402081B3, 1'b0, wb);
        send(4'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd8, 32'h0020A423, 1'b0, wc2);
        check_eq("stall_waits", 32'(wb), 32'd3);
        check_eq("resume_waits", 32'(wc2), 32'd0);
        idle();
      end
      begin
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check_eq("stall_ready", {31'd0, in_ready}, 32'd0);
          check_eq("stall_valid", {31'd0, out_valid}, 32'd1);
          check_eq("stall_instr", out_instr, ea.instr);
          check_eq("stall_pc", out_pc, ea.pc);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with a word pending.
    out_ready = 1'b0;
    send(4'd1, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFFFFFF, 32'hFFF00293, 1'b0, w);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("arst_instr", out_instr, NOP);
    check_eq("arst_pc", out_pc, BASE);
    check_eq("arst_err", {31'd0, out_err}, 32'd0);
    check_eq("arst_wc", {16'd0, word_count}, 32'd0);
    check_eq("arst_ec", {24'd0, err_count}, 32'd0);
    sb_q.delete();
    m_wc = 0;
    m_ec = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 32'h002081B3, 1'b0, w);
    idle();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming RISC-V RV32I instruction encoder, the inverse of the main control decoder.
- Accepts one operation request per handshake: instruction class, register indices, funct bits and a full 32-bit immediate. Emits the packed 32-bit instruction word, its program address and an error flag.
- Feeds the instruction-memory loader and the self-checking benches that generate maze-solver programs.
- Covers the same nine opcode classes the core decodes.

Parameters:
- CNT_W, 16, width of the emitted-word counter; wraps modulo 2^CNT_W.
- BASE_ADDR, 32'h0000_0000, program address of word 0.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous restart: drops pending output, zeroes counters.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_class  in  4  encoding: 0 R, 1 I-ALU, 2 LW, 3 SW, 4 BEQ, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC; 9-15 illegal.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_funct3  in  3  used by R and I-ALU only.
- in_funct7b5  in  1  selects SUB/SRA (R) or SRAI (I-ALU shift).
- in_imm  in  32  signed byte offset or value; for LUI/AUIPC, the full upper value.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_instr  out  32  encoded word.
- out_pc  out  32  BASE_ADDR + 4*index of this word.
- out_err  out  1  request was illegal; out_instr carries NOP.
- word_count  out  CNT_W  words accepted since reset or clear.
- err_count  out  8  saturating count of errored words.

Behaviour:
- Reset (rst_n=0, async):
  - out_valid=0, out_instr=32'h0000_0013, out_pc=BASE_ADDR, out_err=0, word_count=0, err_count=0.
  - Reset mid-transfer discards the pending word.
- Output stage:
  - One-deep registered output. in_ready = !clear && (!out_valid || out_ready), so full throughput is 1 word/cycle.
  - On accept, the encoded word appears on out_* at the next edge (latency 1).
  - If out_valid && !out_ready, all out_* hold stable and in_ready=0.
  - If out_valid && out_ready with no new accept, out_valid clears next cycle.
- Opcodes:
  - R 0110011: funct7 = {1'b0, in_funct7b5, 5'b0}.
  - I-ALU 0010011.
  - LW 0000011, f3 = 010.
  - SW 0100011, f3 = 010.
  - BEQ 1100011, f3 = 000.
  - JAL 1101111.
  - JALR 1100111, f3 = 000.
  - LUI 0110111.
  - AUIPC 0010111.
  - Field slicing follows the standard I/S/B/U/J formats. Unused register fields are forced to 0 (e.g. rs2 for I-type, rd for S/B).
- Range checks (any failure sets the error condition):
  - I, LW, SW, JALR: imm in [-2048, 2047].
  - I-ALU shift (f3 001/101): imm in [0, 31]; bit 30 = in_funct7b5 for f3 101, and must be 0 for f3 001.
  - BEQ: imm in [-4096, 4094] and even.
  - JAL: imm in [-1048576, 1048574] and even.
  - LUI/AUIPC: imm[11:0] = 0.
  - Illegal class 9-15.
- Error word: out_instr = 32'h0000_0013, out_err=1, err_count += 1 (saturates at 255).
  - The word is still counted and still consumes a pc slot.
- Counters:
  - word_count increments on each accept; wraps to 0 after 2^CNT_W-1.
  - out_pc = BASE_ADDR + (word_count_before_accept << 2), mod 2^32.
- Clear:
  - clear=1 has priority over accept and over output transfer.
  - Next cycle: out_valid=0, word_count=0, err_count=0.
  - A request presented during clear is not accepted.

Test Plan:
- Reset, then R class, rd=3, rs1=1, rs2=2, f3=0, f7b5=0 -> out_instr=0x002081B3, pc=0x0. Same with f7b5=1 -> 0x402081B3, pc=0x4.
- I-ALU rd=5, rs1=0, imm=-1 -> 0xFFF00293. SW rs1=1, rs2=2, imm=8 -> 0x0020A423. LUI rd=10, imm=0x12345000 -> 0x12345537. All with out_err=0.
- BEQ rs1=1, rs2=2, imm=-4 -> 0xFE208EE3. JAL rd=1, imm=2048 -> 0x001000EF. BEQ imm=3 -> err=1, instr=0x00000013, err_count=1.
- Back-to-back requests with out_ready=0 for 3 cycles -> in_ready=0 and out_* stable. Release -> 1 word/cycle resumes, and pcs are contiguous (0x0, 0x4, 0x8).
- Assert clear while out_valid=1 and word_count=5 -> next cycle out_valid=0, counts 0. Next word gets pc=BASE_ADDR.
- Assert rst_n low mid-stream, then release -> all outputs at reset values; the first subsequent word gets pc=BASE_ADDR.
